// File: rtl/microprogram_sequencer.sv
// Microprogram next-state sequencer: holds the control-store address and
// picks the next one from increment, jump, dispatch, conditional variants
// or a memory wait on MOC with timeout to an abort state.
module microprogram_sequencer #(
    parameter int STATE_W     = 8,
    parameter int RESET_STATE = 0,
    parameter int FETCH_STATE = 1,
    parameter int UNDEF_STATE = 254,
    parameter int ABORT_STATE = 255,
    parameter int MOC_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         ns_sel,
    input  logic [STATE_W-1:0] cr_addr,
    input  logic [STATE_W-1:0] enc_state,
    input  logic               cond_true,
    input  logic               moc,
    input  logic               stall,
    output logic [STATE_W-1:0] state,
    output logic               waiting,
    output logic               mem_err,
    output logic               undef
);

    localparam int CNT_W = ($clog2(MOC_TIMEOUT + 1) < 1) ? 1 : $clog2(MOC_TIMEOUT + 1);

    localparam logic [2:0] NS_SEQ   = 3'b000;
    localparam logic [2:0] NS_JUMP  = 3'b001;
    localparam logic [2:0] NS_DISP  = 3'b010;
    localparam logic [2:0] NS_CJUMP = 3'b011;
    localparam logic [2:0] NS_WAIT  = 3'b100;
    localparam logic [2:0] NS_CDISP = 3'b101;

    localparam logic [STATE_W-1:0] RST_S   = STATE_W'(RESET_STATE);
    localparam logic [STATE_W-1:0] FETCH_S = STATE_W'(FETCH_STATE);
    localparam logic [STATE_W-1:0] UNDEF_S = STATE_W'(UNDEF_STATE);
    localparam logic [STATE_W-1:0] ABORT_S = STATE_W'(ABORT_STATE);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(MOC_TIMEOUT - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               mem_err_q, mem_err_d;
    logic               undef_q, undef_d;

    logic [STATE_W-1:0] state_inc;
    logic [STATE_W-1:0] disp_tgt;
    logic               disp_bad;

    // Dispatch target: an encoder value of zero means the opcode did not decode.
    always_comb begin
        state_inc = state_q + STATE_W'(1);
        disp_bad  = (enc_state == '0);
        disp_tgt  = disp_bad ? UNDEF_S : enc_state;
    end

    // Next-state decode; stall freezes state and counter and suppresses pulses.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        mem_err_d  = 1'b0;
        undef_d    = 1'b0;
        if (stall) begin
            wait_cnt_d = wait_cnt_q;
        end else begin
            case (ns_sel)
                NS_SEQ:   state_d = state_inc;
                NS_JUMP:  state_d = cr_addr;
                NS_DISP: begin
                    state_d = disp_tgt;
                    undef_d = disp_bad;
                end
                NS_CJUMP: state_d = cond_true ? cr_addr : state_inc;
                NS_WAIT: begin
                    if (moc) begin
                        // MOC wins even on the timeout edge.
                        state_d = state_inc;
                    end else if (wait_cnt_q == CNT_LAST) begin
                        state_d   = ABORT_S;
                        mem_err_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                end
                NS_CDISP: begin
                    if (cond_true) begin
                        state_d = disp_tgt;
                        undef_d = disp_bad;
                    end else begin
                        state_d = FETCH_S;
                    end
                end
                default: begin
                    // 11x is not a legal select.
                    state_d = ABORT_S;
                    undef_d = 1'b1;
                end
            endcase
        end
    end

    // State, wait counter and one-cycle status pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RST_S;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
            undef_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
            undef_q    <= undef_d;
        end
    end

    assign state   = state_q;
    assign mem_err = mem_err_q;
    assign undef   = undef_q;
    assign waiting = reset & (ns_sel == NS_WAIT) & ~moc;

endmodule

// File: tb/tb_microprogram_sequencer.sv
// Scoreboard bench for microprogram_sequencer: directed scenarios then random
// traffic, checked against a behavioural model of the sequencing rules.
module tb_microprogram_sequencer;

    localparam int TO    = 15;
    localparam int UNDEF = 254;
    localparam int ABORT = 255;
    localparam int FETCH = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] ns_sel;
    logic [7:0] cr_addr, enc_state;
    logic       cond_true, moc, stall;
    logic [7:0] state;
    logic       waiting, mem_err, undef;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int st;
        bit me;
        bit ud;
    } exp_t;

    exp_t eq[$];
    bit   wq[$];

    int m_state = 0;
    int m_wait  = 0;   // consecutive unanswered WAIT cycles

    microprogram_sequencer dut (
        .clk(clk), .reset(reset), .ns_sel(ns_sel), .cr_addr(cr_addr),
        .enc_state(enc_state), .cond_true(cond_true), .moc(moc), .stall(stall),
        .state(state), .waiting(waiting), .mem_err(mem_err), .undef(undef)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (reset === 1'b1)
            assert (!$isunknown(ns_sel)) else $error("ns_sel unknown outside reset");

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: registered outputs after each edge that had stimulus.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (eq.size() > 0) begin
            e = eq.pop_front();
            chk("state", int'(state), e.st);
            chk("mem_err", int'(mem_err), int'(e.me));
            chk("undef", int'(undef), int'(e.ud));
        end
    end

    // Monitor: combinational waiting once inputs have settled.
    always @(negedge clk) begin
        bit w;
        #1;
        if (wq.size() > 0) begin
            w = wq.pop_front();
            chk("waiting", int'(waiting), int'(w));
        end
    end

    function automatic int dispatch(input int enc);
        return (enc == 0) ? UNDEF : enc;
    endfunction

    task automatic step(input int ns, input int cr, input int enc,
                        input bit cond, input bit mc, input bit stl);
        exp_t e;
        int nxt;
        @(negedge clk);
        ns_sel = 3'(ns); cr_addr = 8'(cr); enc_state = 8'(enc);
        cond_true = cond; moc = mc; stall = stl;
        wq.push_back(ns == 4 && !mc);
        e.me = 1'b0; e.ud = 1'b0;
        nxt = m_state;
        if (!stl) begin
            if (ns != 4) m_wait = 0;
            case (ns)
                0: nxt = (m_state + 1) % 256;
                1: nxt = cr;
                2: begin nxt = dispatch(enc); e.ud = (enc == 0); end
                3: nxt = cond ? cr : (m_state + 1) % 256;
                4: begin
                    if (mc) begin
                        nxt = (m_state + 1) % 256; m_wait = 0;
                    end else if (m_wait + 1 == TO) begin
                        nxt = ABORT; e.me = 1'b1; m_wait = 0;
                    end else begin
                        m_wait++;
                    end
                end
                5: begin
                    if (cond) begin nxt = dispatch(enc); e.ud = (enc == 0); end
                    else nxt = FETCH;
                end
                default: begin nxt = ABORT; e.ud = 1'b1; end
            endcase
        end
        m_state = nxt;
        e.st = nxt;
        eq.push_back(e);
    endtask

    // Assert reset mid-cycle, check it takes effect without an edge, then
    // release with stall high so the idle edge that follows changes nothing.
    task automatic do_reset(input int hold);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("rst_state", int'(state), 0);
        chk("rst_mem_err", int'(mem_err), 0);
        chk("rst_undef", int'(undef), 0);
        chk("rst_waiting", int'(waiting), 0);
        m_state = 0; m_wait = 0;
        stall = 1'b1;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; ns_sel = 3'b000; cr_addr = '0; enc_state = '0;
        cond_true = 1'b0; moc = 1'b0; stall = 1'b1;
        #1;
        chk("init_state", int'(state), 0);
        chk("init_waiting", int'(waiting), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Run away from 0, then reset asynchronously mid-cycle.
        step(1, 8'h33, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        do_reset(1);

        // SEQ wrap and JUMP.
        step(1, 254, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 8'h40, 0, 0, 0, 0);

        // DISP, undecoded DISP, CDISP with false condition, CJUMP both ways.
        step(2, 0, 37, 0, 0, 0);
        step(2, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(5, 0, 99, 0, 0, 0);
        step(5, 0, 0, 1, 0, 0);
        step(3, 8'h80, 0, 1, 0, 0);
        step(3, 8'h80, 0, 0, 0, 0);

        // WAIT answered on the 4th cycle.
        step(1, 20, 0, 0, 0, 0);
        repeat (3) step(4, 0, 0, 0, 0, 0);
        step(4, 0, 0, 0, 1, 0);

        // WAIT never answered: abort after TO cycles.
        step(1, 50, 0, 0, 0, 0);
        repeat (TO) step(4, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Stall mid-wait at count 10, then timeout after 5 live cycles.
        step(1, 60, 0, 0, 0, 0);
        repeat (10) step(4, 0, 0, 0, 0, 0);
        repeat (5) step(4, 0, 0, 0, 0, 1);
        repeat (5) step(4, 0, 0, 0, 0, 0);
        step(1, 70, 0, 0, 0, 0);
        // MOC on the timeout edge wins.
        repeat (TO - 1) step(4, 0, 0, 0, 0, 0);
        step(4, 0, 0, 0, 1, 0);

        // Illegal selects.
        step(6, 0, 0, 0, 0, 0);
        step(1, 9, 0, 0, 0, 0);
        step(7, 0, 0, 0, 0, 0);

        // Reset during WAIT, then run past where the timeout would have hit.
        step(1, 90, 0, 0, 0, 0);
        repeat (12) step(4, 0, 0, 0, 0, 0);
        do_reset(1);
        repeat (5) step(4, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Random traffic, with occasional long WAIT bursts and resets.
        for (int i = 0; i < 300; i++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                do_reset(int'($urandom_range(0, 2)));
            end else if (r < 3) begin
                int len;
                len = int'($urandom_range(1, 20));
                for (int k = 0; k < len; k++)
                    step(4, 0, 0, 0, ($urandom_range(0, 9) == 0),
                         ($urandom_range(0, 7) == 0));
            end else begin
                step(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                     ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 9) == 0));
            end
        end

        @(posedge clk);
        #2;
        chk("sb_drained", eq.size() + wq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
